// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle for axi4lite_reg_slave, plus the write/read response encodings it returns.
`timescale 1ns/1ps

package AXI4LiteWriteResp;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } Type;
endpackage

package AXI4LiteReadResp;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } Type;
endpackage

interface axi4lite_reg_slave_if #(
    parameter int ADDR_W = 12
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave terminating accesses into a bank of 32-bit registers; register 0 is a read-only ID,
// register contents are exported flat on regs_o.
`timescale 1ns/1ps

module axi4lite_reg_slave #(
    parameter int          ADDR_W   = 12,
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'h5256_3332
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axi4lite_reg_slave_if.slave        bus,
    output logic [32*NUM_REGS-1:0]     regs_o
);
    localparam int IW = ADDR_W - 2;
    localparam int SW = $clog2(NUM_REGS);

    logic                   aw_held;
    logic [IW-1:0]          aw_idx_q;
    logic                   w_held;
    logic [31:0]            w_data_q;
    logic [3:0]             w_strb_q;
    logic                   bvalid_q;
    AXI4LiteWriteResp::Type bresp_q;

    logic                   rvalid_q;
    logic [31:0]            rdata_q;
    AXI4LiteReadResp::Type  rresp_q;

    logic [31:0]            regs [1:NUM_REGS-1];

    logic                   awready;
    logic                   wready;
    logic                   arready;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   commit;
    logic [IW-1:0]          wr_idx;
    logic [31:0]            wr_data;
    logic [3:0]             wr_strb;
    logic                   wr_mapped;
    AXI4LiteWriteResp::Type wr_resp;
    logic [IW-1:0]          rd_idx;
    logic                   rd_mapped;
    logic [31:0]            rd_word;

    // Byte offsets within a word carry no meaning here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, bus.awaddr[1:0], bus.araddr[1:0]};

    assign awready     = !aw_held && !bvalid_q;
    assign wready      = !w_held && !bvalid_q;
    assign arready     = !rvalid_q;

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign aw_hs = bus.awvalid && awready;
    assign w_hs  = bus.wvalid && wready;
    assign ar_hs = bus.arvalid && arready;

    // A channel arriving on this edge counts as held, so the commit lands on the later handshake edge.
    always_comb begin
        commit    = (aw_held || aw_hs) && (w_held || w_hs);
        wr_idx    = aw_held ? aw_idx_q : bus.awaddr[ADDR_W-1:2];
        wr_data   = w_held ? w_data_q : bus.wdata;
        wr_strb   = w_held ? w_strb_q : bus.wstrb;
        wr_mapped = 32'(wr_idx) < 32'(NUM_REGS);
        wr_resp   = AXI4LiteWriteResp::OKAY;
        if (!wr_mapped) begin
            wr_resp = AXI4LiteWriteResp::DECERR;
        end else if (wr_idx == '0) begin
            wr_resp = AXI4LiteWriteResp::SLVERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= AXI4LiteWriteResp::OKAY;
        end else begin
            if (bvalid_q && bus.bready) begin
                bvalid_q <= 1'b0;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= bus.awaddr[ADDR_W-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= bus.wdata;
                    w_strb_q <= bus.wstrb;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && wr_mapped && (wr_idx != '0)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx[SW-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_idx    = bus.araddr[ADDR_W-1:2];
        rd_mapped = 32'(rd_idx) < 32'(NUM_REGS);
        rd_word   = ID_VALUE;
        if (rd_idx != '0) begin
            rd_word = regs[rd_idx[SW-1:0]];
        end
    end

    // Reads sample the registers before any same-edge commit lands, so they return the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= AXI4LiteReadResp::OKAY;
        end else begin
            if (rvalid_q && bus.rready) begin
                rvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mapped ? rd_word : 32'h0;
                rresp_q  <= rd_mapped ? AXI4LiteReadResp::OKAY : AXI4LiteReadResp::DECERR;
            end
        end
    end

    always_comb begin
        regs_o       = '0;
        regs_o[31:0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs[i];
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Randomized self-checking bench for axi4lite_reg_slave against an array-based register model.
`timescale 1ns/1ps

module tb_axi4lite_reg_slave;
    localparam int          ADDR_W   = 12;
    localparam int          NUM_REGS = 8;
    localparam logic [31:0] ID_VALUE = 32'h5256_3332;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;
    localparam logic [1:0]  DECERR   = 2'b11;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [32*NUM_REGS-1:0] regs_o;
    int                     checks = 0;
    int                     errors = 0;
    logic [31:0]            model [NUM_REGS];

    axi4lite_reg_slave_if #(.ADDR_W(ADDR_W)) bus ();

    axi4lite_reg_slave #(
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .ID_VALUE(ID_VALUE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    endfunction

    function automatic logic [1:0] model_write(input logic [11:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx = int'(addr[11:2]);
        if (idx >= NUM_REGS) return DECERR;
        if (idx == 0) return SLVERR;
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        return OKAY;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [11:0] addr);
        int idx = int'(addr[11:2]);
        if (idx >= NUM_REGS) return 32'h0;
        if (idx == 0) return ID_VALUE;
        return model[idx];
    endfunction

    function automatic logic [1:0] model_rresp(input logic [11:0] addr);
        return (int'(addr[11:2]) >= NUM_REGS) ? DECERR : OKAY;
    endfunction

    function automatic logic [32*NUM_REGS-1:0] model_flat();
        logic [32*NUM_REGS-1:0] v;
        v[31:0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    // Master-side write: AW and W raised after independent delays; on_time is set only if bvalid
    // rises exactly one cycle after the later handshake and not before.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output bit on_time, output bit cleared);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w, early = 0;
        int cyc = 0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            if (bus.bvalid) early = 1;
            @(negedge clk);
            cyc++;
            aw_done |= hs_aw;
            w_done  |= hs_w;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        on_time = aw_done && w_done && !early && (bus.bvalid === 1'b1);
        resp = bus.bresp;
        repeat (b_dly) @(negedge clk);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        cleared = (bus.bvalid === 1'b0);
    endtask

    task automatic axi_read(input logic [11:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output bit on_time);
        bit done = 0;
        int cyc = 0;
        bus.araddr = addr;
        while (!done && cyc < 50) begin
            bus.arvalid = (cyc >= ar_dly);
            done = bus.arvalid && bus.arready;
            @(negedge clk);
            cyc++;
        end
        bus.arvalid = 1'b0;
        on_time = done && (bus.rvalid === 1'b1);
        data = bus.rdata;
        resp = bus.rresp;
        repeat (r_dly) @(negedge clk);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit ok;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got aw/w/ar/b/r=%b expected 11100",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        checks++;
        if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_resp: got bresp=%b rresp=%b rdata=%h expected zeros",
                     bus.bresp, bus.rresp, bus.rdata);
        end
        checks++;
        if (regs_o !== model_flat()) begin
            errors++;
            $display("[TB] FAIL reset_regs: got %h expected %h", regs_o, model_flat());
        end
        axi_read(12'h000, 0, 0, d, r, ok);
        checks++;
        if (!ok || d !== ID_VALUE || r !== OKAY) begin
            errors++;
            $display("[TB] FAIL reset_id_read: got ok=%0d rdata=%h rresp=%b expected 1 %h %b",
                     ok, d, r, ID_VALUE, OKAY);
        end
    endtask

    task automatic test_aw_then_w();
        logic [31:0] d; logic [1:0] r, exp; bit ok, clr;
        exp = model_write(12'h004, 32'hDEADBEEF, 4'hF);
        axi_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 2, 0, r, ok, clr);
        checks++;
        if (!ok || !clr || r !== exp) begin
            errors++;
            $display("[TB] FAIL aw_then_w: got ok=%0d clr=%0d bresp=%b expected 1 1 %b", ok, clr, r, exp);
        end
        axi_read(12'h004, 0, 0, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEADBEEF || r !== OKAY) begin
            errors++;
            $display("[TB] FAIL aw_then_w_read: got ok=%0d rdata=%h rresp=%b expected 1 deadbeef 00", ok, d, r);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r, exp; bit ok, clr;
        exp = model_write(12'h008, 32'h11223344, 4'hF);
        axi_write(12'h008, 32'h11223344, 4'hF, 0, 0, 0, r, ok, clr);
        exp = model_write(12'h008, 32'hAABBCCDD, 4'b0101);
        axi_write(12'h008, 32'hAABBCCDD, 4'b0101, 3, 0, 1, r, ok, clr);
        checks++;
        if (!ok || !clr || r !== exp || regs_o[95:64] !== 32'h11BB33DD) begin
            errors++;
            $display("[TB] FAIL w_before_aw: got ok=%0d bresp=%b reg2=%h expected 1 %b 11bb33dd",
                     ok, r, regs_o[95:64], exp);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r, exp; bit ok, clr;
        exp = model_write(12'h020, 32'hCAFEF00D, 4'hF);
        axi_write(12'h020, 32'hCAFEF00D, 4'hF, 1, 0, 0, r, ok, clr);
        checks++;
        if (!ok || r !== exp || exp !== DECERR || regs_o !== model_flat()) begin
            errors++;
            $display("[TB] FAIL write_decerr: got ok=%0d bresp=%b regs=%h expected 1 %b %h",
                     ok, r, regs_o, DECERR, model_flat());
        end
        exp = model_write(12'h001, 32'h12345678, 4'hF);
        axi_write(12'h001, 32'h12345678, 4'hF, 0, 1, 2, r, ok, clr);
        checks++;
        if (!ok || r !== SLVERR || regs_o !== model_flat()) begin
            errors++;
            $display("[TB] FAIL write_slverr: got ok=%0d bresp=%b regs=%h expected 1 %b %h",
                     ok, r, regs_o, exp, model_flat());
        end
        axi_read(12'h000, 0, 0, d, r, ok);
        checks++;
        if (!ok || d !== ID_VALUE || r !== OKAY) begin
            errors++;
            $display("[TB] FAIL id_after_slverr: got rdata=%h rresp=%b expected %h 00", d, r, ID_VALUE);
        end
        axi_read(12'h020, 1, 0, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== DECERR) begin
            errors++;
            $display("[TB] FAIL read_decerr: got ok=%0d rdata=%h rresp=%b expected 1 0 11", ok, d, r);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] old; logic [1:0] exp;
        bus.awaddr = 12'h00C; bus.araddr = 12'h00C; bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        old = model_rdata(12'h00C);
        exp = model_write(12'h00C, 32'h5, 4'hF);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== exp || bus.rvalid !== 1'b1 || bus.rdata !== old
            || old !== 32'h0 || regs_o[127:96] !== 32'h5) begin
            errors++;
            $display("[TB] FAIL simultaneous: got b=%b bresp=%b r=%b rdata=%h reg3=%h expected 1 %b 1 %h 5",
                     bus.bvalid, bus.bresp, bus.rvalid, bus.rdata, regs_o[127:96], exp, old);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic test_b_backpressure();
        logic [31:0] data; logic [1:0] exp;
        data = $urandom;
        bus.awaddr = 12'h010; bus.wdata = data; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        exp = model_write(12'h010, data, 4'hF);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.awvalid = (i >= 2);
            bus.awaddr  = 12'h014;
            checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== exp || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b_stall[%0d]: got b=%b bresp=%b awr=%b wr=%b expected 1 %b 0 0",
                         i, bus.bvalid, bus.bresp, bus.awready, bus.wready, exp);
            end
            @(negedge clk);
        end
        bus.awvalid = 1'b0;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || regs_o !== model_flat()) begin
            errors++;
            $display("[TB] FAIL b_release: got b=%b awr=%b regs=%h expected 0 1 %h",
                     bus.bvalid, bus.awready, regs_o, model_flat());
        end
    endtask

    task automatic test_r_backpressure();
        logic [31:0] exp;
        exp = model_rdata(12'h010);
        bus.araddr = 12'h010; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.araddr = 12'h004;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== exp || bus.rresp !== OKAY || bus.arready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL r_stall[%0d]: got r=%b rdata=%h arr=%b expected 1 %h 0",
                         i, bus.rvalid, bus.rdata, bus.arready, exp);
            end
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL r_release: got r=%b arr=%b expected 0 1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_reset_mid();
        bus.awaddr = 12'h00C; bus.wdata = 32'hA5A5_0003; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 12'h00C; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || regs_o[127:96] !== 32'hA5A5_0003) begin
            errors++;
            $display("[TB] FAIL reset_mid_pre: got b=%b reg3=%h expected 1 a5a50003", bus.bvalid, regs_o[127:96]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || regs_o !== model_flat()) begin
            errors++;
            $display("[TB] FAIL reset_mid: got b=%b r=%b regs=%h expected 0 0 %h",
                     bus.bvalid, bus.rvalid, regs_o, model_flat());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [11:0] addr; logic [31:0] data, d; logic [3:0] strb; logic [1:0] r, exp; bit ok, clr;
        for (int n = 0; n < 40; n++) begin
            addr = 12'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            exp  = model_write(addr, data, strb);
            axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                      r, ok, clr);
            checks++;
            if (!ok || !clr || r !== exp || regs_o !== model_flat()) begin
                errors++;
                $display("[TB] FAIL rand_write[%0d] addr=%h: got ok=%0d clr=%0d bresp=%b regs=%h expected 1 1 %b %h",
                         n, addr, ok, clr, r, regs_o, exp, model_flat());
            end
            addr = 12'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            axi_read(addr, $urandom_range(0, 2), $urandom_range(0, 2), d, r, ok);
            checks++;
            if (!ok || d !== model_rdata(addr) || r !== model_rresp(addr)) begin
                errors++;
                $display("[TB] FAIL rand_read[%0d] addr=%h: got ok=%0d rdata=%h rresp=%b expected 1 %h %b",
                         n, addr, ok, d, r, model_rdata(addr), model_rresp(addr));
            end
        end
    endtask

    // Everything held valid/ready: both paths should complete on alternate cycles.
    task automatic test_back_to_back();
        logic [31:0] rq[$]; logic [31:0] e; int whs = 0, rhs = 0; bit hs_w, hs_r;
        bus.awaddr = 12'h014; bus.araddr = 12'h014; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.bready = 1'b1; bus.rready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            if (bus.rvalid === 1'b1) begin
                e = (rq.size() > 0) ? rq.pop_front() : 32'hxxxx_xxxx;
                checks++;
                if (bus.rdata !== e) begin
                    errors++;
                    $display("[TB] FAIL b2b_read[%0d]: got %h expected %h", c, bus.rdata, e);
                end
            end
            if (c == 20) break;
            bus.wdata = $urandom;
            hs_r = bus.arready === 1'b1;
            hs_w = (bus.awready === 1'b1) && (bus.wready === 1'b1);
            if (hs_r) begin rq.push_back(model_rdata(12'h014)); rhs++; end
            if (hs_w) begin void'(model_write(12'h014, bus.wdata, 4'hF)); whs++; end
            if (c == 19) begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; end
            @(negedge clk);
        end
        bus.bready = 1'b0; bus.rready = 1'b0;
        checks++;
        if (whs != 10 || rhs != 10 || regs_o !== model_flat()) begin
            errors++;
            $display("[TB] FAIL b2b_throughput: got writes=%0d reads=%0d regs=%h expected 10 10 %h",
                     whs, rhs, regs_o, model_flat());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_aw_then_w();
        test_w_before_aw();
        test_errors();
        test_simultaneous();
        test_b_backpressure();
        test_r_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite slave that terminates write and read transactions into a bank of 32-bit control/status registers and produces the bus responses defined in the `AXI4LiteWriteResp` and `AXI4LiteReadResp` packages. It sits directly downstream of the AXI4-Lite interconnect and upstream of the peripheral logic, which consumes the register contents on a flat output bus. Write responses use `AXI4LiteWriteResp::Type` and read responses use `AXI4LiteReadResp::Type`, with OKAY, SLVERR and DECERR encodings.

## Interface
- ADDR_W, 12, byte-address width of AWADDR/ARADDR
- NUM_REGS, 8, number of 32-bit registers (2..2^(ADDR_W-2))
- ID_VALUE, 32'h5256_3332, constant returned by register 0, which is read-only

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  AXI4LiteWriteResp::Type
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  AXI4LiteReadResp::Type
- rvalid  out  1  read valid
- rready  in  1  read ready
- regs_o  out  32*NUM_REGS  register contents; register i is at bits [32*i+31 : 32*i]

## Operation
- Address decode: idx = addr[ADDR_W-1:2]. addr[1:0] is ignored. An access is mapped when idx < NUM_REGS.
- Write channel state:
  - aw_held: AW captured, with its address stored.
  - w_held: W captured, with data and strobes stored.
  - bvalid: response pending.
- awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
- AW and W may complete handshakes in any order or in the same cycle. Each channel is captured exactly once per transaction.
- Commit happens on the first edge where aw_held && w_held are both true. On that edge:
  - Unmapped address: no register change; bresp=DECERR.
  - idx==0: no change; bresp=SLVERR.
  - Otherwise: each byte b with wstrb[b]=1 is written; bresp=OKAY.
  - In all three cases, bvalid←1 and aw_held, w_held←0.
- bvalid stays high, with bresp stable, until bvalid && bready. It then clears on that edge.
- Read: arready = !rvalid. On an AR handshake edge, rdata, rresp and rvalid are registered from the current register contents:
  - Mapped address: rresp=OKAY. Register 0 returns ID_VALUE.
  - Unmapped address: rdata=0, rresp=DECERR.
- rvalid, rdata and rresp stay stable until rvalid && rready. That handshake clears rvalid on the edge.
- Read and write paths are independent and may be active in the same cycle. If a write commit edge coincides with an AR handshake to the same register, the read returns the pre-write value.
- regs_o[31:0] always equals ID_VALUE.

## Timing
- Reset (rst_n low, asynchronous):
  - Registers 1..NUM_REGS-1 = 0.
  - aw_held = w_held = 0.
  - bvalid = 0, bresp = OKAY (2'b00).
  - rvalid = 0, rresp = OKAY, rdata = 0.
  - awready = wready = arready = 1 from the first cycle after release.
- Reset mid-transaction discards held AW/W and any pending B/R with no response issued.
- Write latency: bvalid is visible in the cycle after the later of the AW and W handshakes, which equals the commit edge. If both handshake in cycle N, bvalid is high in cycle N+1.
- Write throughput: at most one write per 2 cycles with bready tied high. A new AW/W is not accepted while bvalid=1.
- Read latency: rvalid is high in the cycle after the AR handshake. Throughput is one read per 2 cycles with rready tied high.
- regs_o reflects a write in the cycle after the commit edge, coincident with bvalid.
- All outputs are registered or derived only from local state. There are no combinational paths from any *valid/*ready input to any output.

## Test plan
- Reset: hold rst_n low, then release → awready=wready=arready=1, bvalid=rvalid=0, regs_o[63:32]=0. Read addr 0x000 → rdata=32'h52563332, rresp=OKAY.
- AW then W:
  - AW addr 0x004 in cycle 1, W data 32'hDEADBEEF with wstrb=4'hF in cycle 3 → bvalid in cycle 4, bresp=OKAY.
  - Read 0x004 → rdata=32'hDEADBEEF.
- W before AW, with partial strobes: register 2 holds 32'h11223344. Write W data 32'hAABBCCDD with wstrb=4'b0101 first, then AW addr 0x008 → register 2 = 32'h11BB33DD, bresp=OKAY.
- Errors:
  - Write to addr 0x020 (idx 8) → bresp=DECERR, no register change.
  - Write to 0x000 → bresp=SLVERR, register 0 still reads ID_VALUE.
  - Read 0x020 → rdata=0, rresp=DECERR.
- Backpressure:
  - bready held low for 5 cycles → bvalid and bresp stable, awready=wready=0 throughout.
  - rready held low for 5 cycles → rvalid and rdata stable, arready=0.
  - Releasing each ready completes exactly one handshake.
- Simultaneous and reset:
  - AW, W and AR all to 0x00C in the same cycle, register initially 0, write 32'h5 → read returns 0, register becomes 5.
  - Assert rst_n while bvalid=1 → bvalid drops immediately and register 3 is reset to 0.
